// File: rtl/mio_pkg.sv
// Shared constants and types for the mio memory-I/O responder and its clients.
package mio_pkg;

  localparam logic [31:0] MIO_RESET_PC = 32'h10;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mio_req_t;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } mio_rsp_t;

  typedef enum logic [0:0] {
    MIO_INIT,
    MIO_RUN
  } mio_state_e;

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM with byte-masked synchronous write and a registered read port.
module mio_ram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wmask_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register returns zero on non-read cycles so it can feed the response directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= re_i ? mem_q[addr_i] : 32'h0;
    end
  end

endmodule

// File: rtl/mio_responder.sv
// Memory-side responder: zero-fills its RAM after reset, then answers one request per cycle
// with a fixed LATENCY, flagging misaligned or out-of-range accesses.
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        mio_req,
  input  logic        mio_rw,
  input  logic [31:0] mio_addr,
  input  logic [31:0] mio_wdata,
  input  logic [3:0]  mio_wmask,
  output logic        mio_rdy,
  output logic        mio_vld,
  output logic [31:0] mio_rdata,
  output logic        mio_err
);

  mio_state_e           state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic                 rdy_q;
  logic [LATENCY-1:0]   vld_q;
  logic [LATENCY-1:0]   err_q;

  logic                 accept;
  logic                 req_err;
  logic                 ram_we;
  logic                 ram_re;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [31:0]          ram_wdata;
  logic [3:0]           ram_wmask;
  logic [31:0]          ram_rdata;
  logic [31:0]          rdata_tail;
  mio_rsp_t             rsp;

  assign accept  = mio_req & rdy_q;
  assign req_err = (mio_addr[1:0] != 2'b00) | ((mio_addr >> (ADDR_BITS + 2)) != 32'h0);

  // The fill sequence owns the RAM port while in INIT.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mio_addr[ADDR_BITS+1:2];
    ram_wdata = mio_wdata;
    ram_wmask = mio_wmask;
    if (state_q == MIO_INIT) begin
      ram_we    = 1'b1;
      ram_addr  = cnt_q;
      ram_wdata = 32'h0;
      ram_wmask = 4'hF;
    end else begin
      ram_we = accept & ~req_err & mio_rw;
      ram_re = accept & ~req_err & ~mio_rw;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= (INIT_CLEAR != 0) ? MIO_INIT : MIO_RUN;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= (state_q == MIO_RUN);
      if (state_q == MIO_INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_q <= MIO_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & req_err;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  mio_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (clr_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .wmask_i(ram_wmask),
    .rdata_o(ram_rdata)
  );

  // The RAM read register is the first data stage, so data needs one fewer flop than the
  // valid/err pipeline.
  if (LATENCY > 1) begin : g_dpipe
    logic [31:0] data_q [LATENCY-1];
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
          data_q[i] <= 32'h0;
        end
      end else begin
        data_q[0] <= ram_rdata;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
    assign rdata_tail = data_q[LATENCY-2];
  end else begin : g_dnone
    assign rdata_tail = ram_rdata;
  end

  always_comb begin
    rsp.vld   = vld_q[LATENCY-1];
    rsp.err   = err_q[LATENCY-1];
    rsp.rdata = rdata_tail;
  end

  assign mio_rdy   = rdy_q;
  assign mio_vld   = rsp.vld;
  assign mio_err   = rsp.err;
  assign mio_rdata = rsp.rdata;

endmodule

// File: tb/tb_mio_responder.sv
// Drives two responders (ADDR_BITS=4/LATENCY=1 and ADDR_BITS=10/LATENCY=3) with shared
// stimulus and checks each against its own memory model and response queue.
module tb_mio_responder;
  import mio_pkg::*;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        mio_req;
  logic        mio_rw;
  logic [31:0] mio_addr;
  logic [31:0] mio_wdata;
  logic [3:0]  mio_wmask;
  logic        rdy_a, vld_a, err_a;
  logic [31:0] rdata_a;
  logic        rdy_b, vld_b, err_b;
  logic [31:0] rdata_b;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [1024];

  mio_responder #(.ADDR_BITS(4), .LATENCY(1), .INIT_CLEAR(1)) dut_a (
    .clk(clk), .clr_n(clr_n), .mio_req(mio_req), .mio_rw(mio_rw), .mio_addr(mio_addr),
    .mio_wdata(mio_wdata), .mio_wmask(mio_wmask), .mio_rdy(rdy_a), .mio_vld(vld_a),
    .mio_rdata(rdata_a), .mio_err(err_a)
  );

  mio_responder #(.ADDR_BITS(10), .LATENCY(3), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .clr_n(clr_n), .mio_req(mio_req), .mio_rw(mio_rw), .mio_addr(mio_addr),
    .mio_wdata(mio_wdata), .mio_wmask(mio_wmask), .mio_rdy(rdy_b), .mio_vld(vld_b),
    .mio_rdata(rdata_b), .mio_err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Scoreboard: every negedge, pop and compare a response or check the idle state.
  always @(negedge clk) begin
    exp_t e;
    n_chk++;
    if (vld_a === 1'b1) begin
      if (q_a.size() == 0) begin
        $display("FAIL a_unexpected_vld: got vld=1 at cycle %0d, required no response", cyc);
      end else begin
        e = q_a.pop_front();
        if (err_a !== e.err || rdata_a !== e.rdata || cyc != e.cyc)
          $display("FAIL a_response: got err=%b rdata=%h cycle=%0d, required err=%b rdata=%h cycle=%0d",
                   err_a, rdata_a, cyc, e.err, e.rdata, e.cyc);
        else n_pass++;
      end
    end else if (vld_a !== 1'b0 || rdata_a !== 32'h0 || err_a !== 1'b0) begin
      $display("FAIL a_idle: got vld=%b err=%b rdata=%h, required 0 0 0", vld_a, err_a, rdata_a);
    end else if (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
      e = q_a.pop_front();
      $display("FAIL a_missing: got no vld at cycle %0d, required response rdata=%h", cyc, e.rdata);
    end else n_pass++;

    n_chk++;
    if (vld_b === 1'b1) begin
      if (q_b.size() == 0) begin
        $display("FAIL b_unexpected_vld: got vld=1 at cycle %0d, required no response", cyc);
      end else begin
        e = q_b.pop_front();
        if (err_b !== e.err || rdata_b !== e.rdata || cyc != e.cyc)
          $display("FAIL b_response: got err=%b rdata=%h cycle=%0d, required err=%b rdata=%h cycle=%0d",
                   err_b, rdata_b, cyc, e.err, e.rdata, e.cyc);
        else n_pass++;
      end
    end else if (vld_b !== 1'b0 || rdata_b !== 32'h0 || err_b !== 1'b0) begin
      $display("FAIL b_idle: got vld=%b err=%b rdata=%h, required 0 0 0", vld_b, err_b, rdata_b);
    end else if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
      e = q_b.pop_front();
      $display("FAIL b_missing: got no vld at cycle %0d, required response rdata=%h", cyc, e.rdata);
    end else n_pass++;
  end

  // Called at a negedge with both DUTs ready; the request is accepted at the next posedge.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
    exp_t e;
    int   acc;
    acc       = cyc + 1;
    mio_req   = 1'b1;
    mio_rw    = rw;
    mio_addr  = addr;
    mio_wdata = wdata;
    mio_wmask = wmask;
    e.err   = (addr[1:0] != 2'b00) || ((addr >> 6) != 32'h0);
    e.rdata = 32'h0;
    e.cyc   = acc;
    if (!e.err) begin
      if (rw) mem_a[addr[5:2]] = merge(mem_a[addr[5:2]], wdata, wmask);
      else e.rdata = mem_a[addr[5:2]];
    end
    q_a.push_back(e);
    e.err   = (addr[1:0] != 2'b00) || ((addr >> 12) != 32'h0);
    e.rdata = 32'h0;
    e.cyc   = acc + 2;
    if (!e.err) begin
      if (rw) mem_b[addr[11:2]] = merge(mem_b[addr[11:2]], wdata, wmask);
      else e.rdata = mem_b[addr[11:2]];
    end
    q_b.push_back(e);
    @(negedge clk);
    mio_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
  endtask

  task automatic clear_models();
    foreach (mem_a[i]) mem_a[i] = 32'h0;
    foreach (mem_b[i]) mem_b[i] = 32'h0;
  endtask

  task automatic test_reset();
    int ka = -1;
    int kb = -1;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rdy_a, vld_a, err_a, rdy_b, vld_b, err_b} !== 6'b0 || rdata_a !== 32'h0 ||
        rdata_b !== 32'h0)
      $display("FAIL reset_outputs: got rdy/vld/err a=%b%b%b b=%b%b%b rdata a=%h b=%h, required 0",
               rdy_a, vld_a, err_a, rdy_b, vld_b, err_b, rdata_a, rdata_b);
    else n_pass++;
    clr_n = 1'b1;
    for (int k = 1; k <= 1100 && kb < 0; k++) begin
      @(negedge clk);
      if (rdy_a === 1'b1 && ka < 0) ka = k;
      if (rdy_b === 1'b1 && kb < 0) kb = k;
    end
    n_chk++;
    if (ka != 17) $display("FAIL rdy_rise_a: got %0d cycles, required 17", ka);
    else n_pass++;
    n_chk++;
    if (kb != 1025) $display("FAIL rdy_rise_b: got %0d cycles, required 1025", kb);
    else n_pass++;
  endtask

  task automatic test_init_read();
    issue(1'b0, MIO_RESET_PC, 32'h0, 4'h0);
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL init_read_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  task automatic test_write_read();
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL write_read_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  task automatic test_byte_mask();
    issue(1'b1, 32'h14, 32'h11223344, 4'hF);
    issue(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL byte_mask_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  task automatic test_errors();
    issue(1'b0, 32'h12, 32'h0, 4'h0);
    issue(1'b1, 32'h4000, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b1, 32'h10, 32'h12345678, 4'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b1, 32'h40, 32'h5555AAAA, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    issue(1'b1, 32'h8000_0010, 32'hFFFFFFFF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL errors_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first_acc;
    int first = -1;
    int last  = -1;
    int nv    = 0;
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h10 + 4 * i, i, 4'hF);
    wait_drain();
    first_acc = cyc + 1;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(1'b0, 32'h10 + 4 * i, 32'h0, 4'h0);
      end
      begin
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          if (vld_b === 1'b1) begin
            if (first < 0) first = cyc;
            last = cyc;
            nv++;
          end
        end
      end
    join
    n_chk++;
    if (nv != 8 || first != first_acc + 2 || last - first != 7)
      $display("FAIL stream_window: got %0d pulses from %0d to %0d, required 8 from %0d to %0d",
               nv, first, last, first_acc + 2, first_acc + 9);
    else n_pass++;
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL stream_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    issue(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    #2;
    clr_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    n_chk++;
    if ({rdy_a, vld_a, err_a, rdy_b, vld_b, err_b} !== 6'b0 || rdata_b !== 32'h0)
      $display("FAIL mid_reset_outputs: got a=%b%b%b b=%b%b%b rdata_b=%h, required 0",
               rdy_a, vld_a, err_a, rdy_b, vld_b, err_b, rdata_b);
    else n_pass++;
    repeat (3) @(negedge clk);
    clear_models();
    clr_n = 1'b1;
    while (k < 1100 && !(rdy_a === 1'b1 && rdy_b === 1'b1)) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k != 1025) $display("FAIL mid_reinit: got ready after %0d cycles, required 1025", k);
    else n_pass++;
    issue(1'b0, MIO_RESET_PC, 32'h0, 4'h0);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    wait_drain();
    n_chk++;
    if (q_a.size() + q_b.size() != 0)
      $display("FAIL mid_drain: got %0d outstanding, required 0", q_a.size() + q_b.size());
    else n_pass++;
  endtask

  initial begin
    clr_n     = 1'b0;
    mio_req   = 1'b0;
    mio_rw    = 1'b0;
    mio_addr  = 32'h0;
    mio_wdata = 32'h0;
    mio_wmask = 4'h0;
    clear_models();
    test_reset();
    test_init_read();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
# mio_responder

Memory-side responder for the core's memory I/O (`mio_*`) interface: the block that answers fetch and load/store requests with `mio_vld`/`mio_rdata`. It contains a word-addressed, byte-maskable RAM. After reset it runs a zero-fill sequence, then serves one request per cycle with a fixed, parameterised response latency. It sits between the pipeline's fetch/memory stages and the simulation/FPGA memory model, and is the bench target for fetch bring-up from the reset PC `0x10`.

## Interface
- `ADDR_BITS`, default 10: log2 of RAM depth in 32-bit words; byte space is `2^(ADDR_BITS+2)`.
- `LATENCY`, default 1: cycles from request accept to `mio_vld`; legal range 1..4.
- `INIT_CLEAR`, default 1: 1 = zero-fill the RAM after reset; 0 = skip straight to RUN.
- `clk` in 1: sole clock; all logic on the rising edge.
- `clr_n` in 1: reset, asynchronous and active-low.
- `mio_req` in 1: request valid.
- `mio_rw` in 1: 1 = write, 0 = read.
- `mio_addr` in 32: byte address.
- `mio_wdata` in 32: write data.
- `mio_wmask` in 4: byte enables for writes; bit i enables `wdata[8i+7:8i]`.
- `mio_rdy` out 1: responder can accept a request this cycle.
- `mio_vld` out 1: response valid; a single-cycle pulse per accepted request.
- `mio_rdata` out 32: read data; 0 for writes and errors.
- `mio_err` out 1: qualifies `mio_vld`; set for a misaligned or out-of-range request.

## Operation
- FSM states: INIT, RUN.
- Reset: state = INIT (RUN if `INIT_CLEAR=0`), fill counter = 0, pipeline valids cleared.
- INIT:
  - Writes 0 to word `cnt` each cycle and increments `cnt`.
  - At `cnt == 2^ADDR_BITS-1` the write completes, then state goes to RUN next cycle.
  - `mio_rdy=0` throughout INIT.
- RUN: `mio_rdy=1` permanently; accept = `mio_req & mio_rdy`.
- Error check at accept: `err = (addr[1:0]!=0) | (addr[31:ADDR_BITS+2]!=0)`.
- Accepted write, no error:
  - RAM word `addr[ADDR_BITS+1:2]` is updated in the accept cycle under `mio_wmask`.
  - `wmask=0` is legal: no update, normal response.
- Accepted read, no error: RAM is read in the accept cycle.
- Errored request: no RAM update; the response carries `err=1`, `rdata=0`.
- Each accept pushes {valid, err, rw, data} into a LATENCY-deep shift pipeline; the tail drives `mio_vld`/`mio_err`/`mio_rdata`.
- Ordering: responses are returned strictly in accept order, one per accepted request, never merged or dropped.
- Read-after-write: a read accepted any cycle after a write to the same word returns the written data. There is no same-cycle case (one request per cycle).
- `mio_req` while `mio_rdy=0` is ignored, not queued.

## Timing
- Reset values (asserted immediately, asynchronous): `mio_rdy=0`, `mio_vld=0`, `mio_rdata=0`, `mio_err=0`.
- INIT duration: `2^ADDR_BITS` cycles after `clr_n` deasserts; `mio_rdy` rises on the following edge.
- Request accepted at edge T → `mio_vld` high for the cycle following edge T+LATENCY-1; e.g. LATENCY=1 gives the response in the next cycle.
- Back-to-back accepts → back-to-back `mio_vld` pulses; throughput is 1/cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- `mio_rdata`/`mio_err` hold 0 when `mio_vld=0`.
- Reset mid-operation:
  - In-flight responses are discarded.
  - FSM restarts in INIT; RAM contents are re-cleared.
  - With `INIT_CLEAR=0`, RAM contents are undefined-retained.

## Structure
- Shared package `mio_pkg`:
  - `MIO_RESET_PC = 32'h10`.
  - `mio_req_t` struct {rw, addr, wdata, wmask}.
  - `mio_rsp_t` struct {vld, err, rdata}.
  - FSM state enum `{MIO_INIT, MIO_RUN}`.
- One sub-module `mio_ram`:
  - Single-port, synchronous-write, byte-masked RAM of `2^ADDR_BITS`×32.
  - Has a registered read port; the pipeline depth is adjusted for it.
  - No reset on the array.
- Top: FSM, fill counter, error decode, response shift pipeline.

## Test plan
- Reset/INIT, ADDR_BITS=4:
  - During reset, all outputs are 0.
  - `mio_rdy` rises exactly 17 cycles after `clr_n` rises.
  - Read of `0x10` returns `rdata=0`, `err=0`.
- Write/read, LATENCY=1:
  - Write `0x10`, `wdata=0xDEADBEEF`, `wmask=4'hF`, then read `0x10`.
  - `vld` pulses on both; the read returns `0xDEADBEEF` one cycle after its accept.
- Byte mask:
  - Write `0x14=0x11223344` with mask F, then write `0xAABBCCDD` with mask `4'b0101`.
  - Read `0x14` returns `0x11BB33DD`.
- Errors:
  - Read `0x12` → `vld=1`, `err=1`, `rdata=0`.
  - Write `0x4000` with ADDR_BITS=10 → `err=1`, and RAM is unchanged on readback.
- Streaming, LATENCY=3:
  - 8 back-to-back reads of `0x10..0x2C` (preloaded with `i`).
  - `vld` is high for 8 consecutive cycles starting 3 cycles after the first accept, with `rdata` = 0..7 in order.
- Reset mid-stream:
  - Assert `clr_n=0` with 2 responses in flight.
  - No further `vld` appears, INIT reruns, and a readback of `0x10` returns 0.
